// File: rtl/sha256_hash_serialiser.sv
// Purpose : serialise 256-bit SHA-256 digests into OUT_WIDTH-bit words and count finished digests.
// Latency : first word valid 1 cycle after a digest is accepted; back-to-back digests stream bubble-free.
// Backpr. : output holds its word while valid & ~ready; input ready only when empty or the final word leaves.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   en                   clock enable; when low all state holds and no handshake completes
//   sync_rst             synchronous reset, acts regardless of en
//   data_in*             256-bit digest in (valid/ready/last)
//   data_out*            OUT_WIDTH-bit word out (valid/ready/last)
//   status_hash_cnt      digests fully emitted since reset (wraps)
module sha256_hash_serialiser #(
    parameter int OUT_WIDTH = 32,   // must divide 256: 32, 64, 128 or 256
    parameter bit MSW_FIRST = 1'b1  // 1: H0 word first, 0: least-significant word first
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic                 sync_rst,
    input  logic [255:0]         data_in,
    input  logic                 data_in_last,
    input  logic                 data_in_valid,
    output logic                 data_in_ready,
    output logic [OUT_WIDTH-1:0] data_out,
    output logic                 data_out_last,
    output logic                 data_out_valid,
    input  logic                 data_out_ready,
    output logic [31:0]          status_hash_cnt
);

    localparam int N  = 256 / OUT_WIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   hash_q, hash_d;
    logic           last_q, last_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    hash_cnt_q, hash_cnt_d;

    logic           full_q;
    logic           cnt_last;
    logic           in_fire;
    logic           out_fire;
    logic [CW-1:0]  word_idx;
    logic [7:0]     word_base;

    assign full_q   = (state_q == ST_SEND);
    assign cnt_last = (cnt_q == CNT_LAST);

    // data_out_ready feeds data_in_ready combinationally so the next digest
    // can load in the same cycle the final word leaves.
    assign data_out_valid = en & full_q;
    assign data_in_ready  = en & (~full_q | (cnt_last & data_out_ready));
    assign data_out_last  = full_q & last_q & cnt_last;
    assign in_fire        = en & data_in_valid & data_in_ready;
    assign out_fire       = en & data_out_valid & data_out_ready;
    assign status_hash_cnt = hash_cnt_q;

    // Word k counted from the LSB end; MSW-first walks it downward.
    always_comb begin
        word_idx  = MSW_FIRST ? (CNT_LAST - cnt_q) : cnt_q;
        word_base = 8'(word_idx) * 8'(OUT_WIDTH);
        data_out  = hash_q[word_base +: OUT_WIDTH];
    end

    always_comb begin
        state_d    = state_q;
        hash_d     = hash_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        hash_cnt_d = hash_cnt_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    hash_d  = data_in;
                    last_d  = data_in_last;
                    cnt_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (out_fire) begin
                    if (!cnt_last) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        cnt_d      = '0;
                        hash_cnt_d = hash_cnt_q + 32'd1;
                        // Only reachable here: the refill path of the double buffer.
                        if (in_fire) begin
                            hash_d = data_in;
                            last_d = data_in_last;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_EMPTY;
            hash_q     <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            hash_cnt_q <= '0;
        end else if (sync_rst) begin
            state_q    <= ST_EMPTY;
            hash_q     <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            hash_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hash_q     <= hash_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            hash_cnt_q <= hash_cnt_d;
        end
    end

endmodule

// File: tb/tb_sha256_hash_serialiser.sv
module tb_sha256_hash_serialiser;

    logic clk = 1'b0;
    logic nrst, en, sync_rst;

    // 32-bit, MSW-first instance
    logic [255:0] a_in_dat;
    logic         a_in_last, a_in_valid, a_in_ready;
    logic [31:0]  a_out;
    logic         a_last, a_out_valid, a_out_ready;
    logic [31:0]  a_hcnt;

    // 64-bit, LSW-first instance
    logic [255:0] b_in_dat;
    logic         b_in_last, b_in_valid, b_in_ready;
    logic [63:0]  b_out;
    logic         b_last, b_out_valid, b_out_ready;
    logic [31:0]  b_hcnt;

    always #5 clk = ~clk;

    sha256_hash_serialiser #(.OUT_WIDTH(32), .MSW_FIRST(1'b1)) u_a (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .data_in(a_in_dat), .data_in_last(a_in_last), .data_in_valid(a_in_valid),
        .data_in_ready(a_in_ready), .data_out(a_out), .data_out_last(a_last),
        .data_out_valid(a_out_valid), .data_out_ready(a_out_ready),
        .status_hash_cnt(a_hcnt)
    );

    sha256_hash_serialiser #(.OUT_WIDTH(64), .MSW_FIRST(1'b0)) u_b (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .data_in(b_in_dat), .data_in_last(b_in_last), .data_in_valid(b_in_valid),
        .data_in_ready(b_in_ready), .data_out(b_out), .data_out_last(b_last),
        .data_out_valid(b_out_valid), .data_out_ready(b_out_ready),
        .status_hash_cnt(b_hcnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: words pushed when a digest is handed over, popped on each output fire.
    typedef struct {
        logic [255:0] w;
        logic         l;
    } exp_t;
    exp_t a_q[$];
    exp_t b_q[$];
    exp_t ea, eb;

    always @(negedge clk) begin
        if (nrst && a_out_valid && a_out_ready) begin
            if (a_q.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected: word %0h emitted with nothing expected", a_out);
            end else begin
                ea = a_q.pop_front();
                chk("a_sb_data", 256'(a_out), ea.w);
                chk("a_sb_last", 256'(a_last), 256'(ea.l));
            end
        end
        if (nrst && a_in_valid && a_in_ready)
            for (int j = 0; j < 8; j++)
                a_q.push_back('{w: 256'(a_in_dat[255-32*j -: 32]), l: a_in_last && (j == 7)});
    end

    always @(negedge clk) begin
        if (nrst && b_out_valid && b_out_ready) begin
            if (b_q.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: word %0h emitted with nothing expected", b_out);
            end else begin
                eb = b_q.pop_front();
                chk("b_sb_data", 256'(b_out), eb.w);
                chk("b_sb_last", 256'(b_last), 256'(eb.l));
            end
        end
        if (nrst && b_in_valid && b_in_ready)
            for (int j = 0; j < 4; j++)
                b_q.push_back('{w: 256'(b_in_dat[64*j +: 64]), l: b_in_last && (j == 3)});
    end

    // Hands one digest to the 32-bit instance while it is empty.
    task automatic a_accept(input logic [255:0] d, input logic l);
        a_in_dat   = d;
        a_in_last  = l;
        a_in_valid = 1'b1;
        @(negedge clk);
        chk("a_acc_rdy", 256'(a_in_ready), 256'(1));
        step();
        a_in_valid = 1'b0;
    endtask

    typedef struct {
        logic [255:0] dig;
        logic         lst;
        logic [31:0]  first_w;
        logic [31:0]  final_w;
    } vec_t;
    vec_t vecs[3];

    localparam logic [255:0] ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] d[3];
        logic [255:0] z;
        logic [63:0]  b_exp[4];
        logic [31:0]  prev_dat;
        logic         prev_stall, done, fired;
        int           exp_hcnt, k, wc;

        vecs[0] = '{dig: ABC, lst: 1'b1, first_w: 32'hba7816bf, final_w: 32'hf20015ad};
        vecs[1] = '{dig: 256'h00112233_44556677_8899aabb_ccddeeff_01234567_89abcdef_fedcba98_76543210,
                    lst: 1'b0, first_w: 32'h00112233, final_w: 32'h76543210};
        vecs[2] = '{dig: {32'h80000000, 192'h0, 32'h00000001},
                    lst: 1'b1, first_w: 32'h80000000, final_w: 32'h00000001};
        b_exp[0] = 64'hb410ff61f20015ad;
        b_exp[1] = 64'hb00361a396177a9c;
        b_exp[2] = 64'h414140de5dae2223;
        b_exp[3] = 64'hba7816bf8f01cfea;

        nrst = 1'b0; en = 1'b0; sync_rst = 1'b0;
        a_in_dat = '0; a_in_last = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_dat = '0; b_in_last = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        exp_hcnt = 0;

        // Reset state
        #12;
        chk("rst_vld",  256'(a_out_valid), 256'(0));
        chk("rst_rdy",  256'(a_in_ready),  256'(0));
        chk("rst_dat",  256'(a_out),       256'(0));
        chk("rst_last", 256'(a_last),      256'(0));
        chk("rst_hcnt", 256'(a_hcnt),      256'(0));
        nrst = 1'b1;
        step();
        en = 1'b1;
        #1;
        chk("rst_rdy_en", 256'(a_in_ready), 256'(1));
        step();

        // Table-driven single digests, sink always ready
        foreach (vecs[i]) begin
            a_accept(vecs[i].dig, vecs[i].lst);
            for (int w = 0; w < 8; w++) begin
                @(negedge clk);
                chk("tbl_vld", 256'(a_out_valid), 256'(1));
                if (w == 0) chk("tbl_first", 256'(a_out), 256'(vecs[i].first_w));
                if (w == 7) begin
                    chk("tbl_final", 256'(a_out), 256'(vecs[i].final_w));
                    chk("tbl_lastflag", 256'(a_last), 256'(vecs[i].lst));
                end
                step();
            end
            @(negedge clk);
            chk("tbl_drained", 256'(a_out_valid), 256'(0));
            exp_hcnt++;
            chk("tbl_hcnt", 256'(a_hcnt), 256'(exp_hcnt));
            step();
        end

        // Back-to-back: three digests, valid held high
        for (int i = 0; i < 3; i++)
            d[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        a_in_dat = d[0]; a_in_last = 1'b0; a_in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_rdy0", 256'(a_in_ready), 256'(1));
        step();
        k = 1; a_in_dat = d[1];
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            chk("b2b_vld", 256'(a_out_valid), 256'(1));
            chk("b2b_rdy", 256'(a_in_ready), 256'(j % 8 == 7));
            fired = a_in_valid && a_in_ready;
            step();
            if (fired) begin
                k++;
                if (k < 3) begin
                    a_in_dat = d[k]; a_in_last = (k == 2);
                end else begin
                    a_in_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("b2b_drained", 256'(a_out_valid), 256'(0));
        exp_hcnt += 3;
        chk("b2b_hcnt", 256'(a_hcnt), 256'(exp_hcnt));
        step();

        // Backpressure: sink ready one cycle in three, next digest waiting
        a_accept(vecs[1].dig, 1'b1);
        a_in_dat = vecs[2].dig; a_in_last = 1'b0; a_in_valid = 1'b1;
        prev_stall = 1'b0; prev_dat = '0; done = 1'b0; wc = 0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            a_out_ready = (cyc % 3 == 2);
            @(negedge clk);
            if (prev_stall) chk("bp_stable", 256'(a_out), 256'(prev_dat));
            chk("bp_vld", 256'(a_out_valid), 256'(1));
            chk("bp_rdy", 256'(a_in_ready), 256'(wc == 7 && a_out_ready));
            prev_stall = a_out_valid && !a_out_ready;
            prev_dat   = a_out;
            fired = a_out_valid && a_out_ready;
            if (fired && wc == 7) done = 1'b1;
            if (fired) wc++;
            step();
        end
        a_in_valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL bp_timeout: words sent %0d required 8", wc);
        end
        a_out_ready = 1'b1;
        repeat (8) step();
        @(negedge clk);
        chk("bp_drained", 256'(a_out_valid), 256'(0));
        exp_hcnt += 2;
        chk("bp_hcnt", 256'(a_hcnt), 256'(exp_hcnt));
        step();

        // 64-bit LSW-first instance, last=0
        b_in_dat = ABC; b_in_last = 1'b0; b_in_valid = 1'b1;
        @(negedge clk);
        chk("w64_acc_rdy", 256'(b_in_ready), 256'(1));
        step();
        b_in_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("w64_vld",  256'(b_out_valid), 256'(1));
            chk("w64_word", 256'(b_out), 256'(b_exp[j]));
            chk("w64_last", 256'(b_last), 256'(0));
            step();
        end
        @(negedge clk);
        chk("w64_drained", 256'(b_out_valid), 256'(0));
        chk("w64_hcnt", 256'(b_hcnt), 256'(1));
        step();

        // en low for 5 cycles during the 4th word
        z = vecs[0].dig;
        a_accept(z, 1'b1);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            step();
        end
        en = 1'b0;
        a_in_dat = vecs[1].dig; a_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("en0_vld", 256'(a_out_valid), 256'(0));
            chk("en0_rdy", 256'(a_in_ready), 256'(0));
            chk("en0_hold", 256'(a_out), 256'(z[159:128]));
            step();
        end
        en = 1'b1; a_in_valid = 1'b0;
        @(negedge clk);
        chk("en1_resume_vld", 256'(a_out_valid), 256'(1));
        chk("en1_resume_w", 256'(a_out), 256'(z[159:128]));
        repeat (5) step();
        @(negedge clk);
        chk("en_drained", 256'(a_out_valid), 256'(0));
        exp_hcnt++;
        chk("en_hcnt", 256'(a_hcnt), 256'(exp_hcnt));
        step();

        // sync_rst for one cycle during the 4th word
        a_accept(vecs[1].dig, 1'b1);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            step();
        end
        sync_rst = 1'b1;
        @(negedge clk);
        step();
        sync_rst = 1'b0;
        a_q.delete();
        b_q.delete();
        @(negedge clk);
        chk("sr_vld",  256'(a_out_valid), 256'(0));
        chk("sr_hcnt", 256'(a_hcnt), 256'(0));
        chk("sr_dat",  256'(a_out), 256'(0));
        chk("sr_last", 256'(a_last), 256'(0));
        chk("sr_rdy",  256'(a_in_ready), 256'(1));
        exp_hcnt = 0;
        step();
        z = vecs[2].dig;
        a_accept(z, 1'b0);
        @(negedge clk);
        chk("sr_restart_w0", 256'(a_out), 256'(z[255:224]));
        repeat (8) step();
        @(negedge clk);
        chk("sr_drained", 256'(a_out_valid), 256'(0));
        exp_hcnt++;
        chk("sr_hcnt2", 256'(a_hcnt), 256'(exp_hcnt));
        step();

        // Asynchronous reset between clock edges mid-digest
        a_accept(ABC, 1'b1);
        @(negedge clk);
        step();
        #2;
        nrst = 1'b0;
        #1;
        chk("arst_vld",  256'(a_out_valid), 256'(0));
        chk("arst_last", 256'(a_last), 256'(0));
        chk("arst_dat",  256'(a_out), 256'(0));
        chk("arst_hcnt", 256'(a_hcnt), 256'(0));
        chk("arst_rdy",  256'(a_in_ready), 256'(1));
        a_q.delete();
        b_q.delete();
        @(negedge clk);
        #1;
        nrst = 1'b1;
        step();
        @(negedge clk);
        chk("arst_after_vld", 256'(a_out_valid), 256'(0));
        step();

        chk("a_sb_empty", 256'(a_q.size()), 256'(0));
        chk("b_sb_empty", 256'(b_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_hash_serialiser.md
Name: sha256_hash_serialiser

Overview:
- Output-side reader for the SHA-256 hashing stream.
- Accepts 256-bit digests over the stream's valid/ready/last data-out interface and emits them as narrow words over valid/ready/last for a 32-bit bus or stream sink.
- Double-buffered: a new digest is accepted in the same cycle the final word of the current one leaves, so back-to-back digests stream with no bubble.
- Also counts completed digests for status.

Parameters:
- OUT_WIDTH, 32, output word width in bits; must divide 256 exactly (legal: 32, 64, 128, 256).
- MSW_FIRST, 1, 1 = most-significant word (H0) first; 0 = least-significant word first.

Ports:
- clk  input  1  clock.
- nrst  input  1  asynchronous active-low reset.
- en  input  1  clock enable; when 0, all state holds and no handshake completes.
- sync_rst  input  1  synchronous localised reset.
- data_in  input  256  digest from the hashing stream.
- data_in_last  input  1  digest is the final one of the batch.
- data_in_valid  input  1  digest valid.
- data_in_ready  output  1  serialiser can accept a digest.
- data_out  output  OUT_WIDTH  current output word.
- data_out_last  output  1  final word of a digest whose data_in_last was 1.
- data_out_valid  output  1  output word valid.
- data_out_ready  input  1  sink accepts the word.
- status_hash_cnt  output  32  number of digests fully emitted since reset.

Behaviour:
- Reset: clk and reset as stated; nrst is asynchronous and active-low.
- N = 256/OUT_WIDTH words per digest; word counter cnt is $clog2(N) bits (1 bit minimum). For N=1, cnt is held at 0.
- State: hash_q[255:0], last_q, full_q, cnt, hash_cnt_q.
- On nrst low, and on sync_rst high at a clk edge (sync_rst acts regardless of en):
  - all state = 0.
  - Outputs read data_out_valid=0, data_in_ready=0 while en=0, data_out_last=0, status_hash_cnt=0, data_out=0.
- Priority: nrst > sync_rst > en.
- Handshake fires:
  - in_fire = en & data_in_valid & data_in_ready.
  - out_fire = en & data_out_valid & data_out_ready.
- data_out_valid = en & full_q.
- data_in_ready = en & (~full_q | (cnt==N-1 & data_out_ready)). The combinational path from data_out_ready to data_in_ready is intentional.
- Word select:
  - MSW_FIRST=1: data_out = hash_q[255-OUT_WIDTH*cnt -: OUT_WIDTH].
  - MSW_FIRST=0: data_out = hash_q[OUT_WIDTH*cnt +: OUT_WIDTH].
- data_out_last = full_q & last_q & (cnt==N-1).
- Control states (encoded by full_q):
  - EMPTY (full_q=0): in_fire loads hash_q/last_q, cnt=0, full_q=1. Output valid appears the cycle after acceptance (latency 1).
  - SEND (full_q=1), out_fire with cnt<N-1: cnt+1.
  - SEND, out_fire with cnt==N-1: cnt=0 and hash_cnt_q+1. If in_fire in the same cycle, load the new digest and stay full; else full_q=0.
  - SEND without out_fire: hold everything. data_out is stable while valid & ~ready.
- data_in_valid while full and not on the final word: ignored (ready=0); no data loss.
- status_hash_cnt wraps from 2^32-1 to 0.
- en=0 mid-digest: freeze cnt and hash_q; on en=1, resume at the same word.
- sync_rst mid-digest: the partial digest is discarded and no last word is emitted.

Test Plan:
- Single digest, MSW_FIRST=1, OUT_WIDTH=32, data_out_ready=1:
  - Stimulus: data_in = SHA-256("abc") = ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad, last=1.
  - Required: 8 words ba7816bf..f20015ad on consecutive cycles, first valid 1 cycle after accept, data_out_last only on f20015ad, status_hash_cnt=1.
- Back-to-back digests:
  - Stimulus: 3 digests with data_in_valid held high, sink always ready.
  - Required: 24 consecutive valid cycles with no gap, data_in_ready high only on cnt=7 cycles, status_hash_cnt=3.
- Backpressure:
  - Stimulus: toggle data_out_ready with a 1-in-3 pattern.
  - Required: data_out stable while valid & ~ready, word order unchanged, data_in_ready=0 until the final word fires.
- MSW_FIRST=0, OUT_WIDTH=64, "abc" digest with last=0:
  - Required: words b410ff61f20015ad, b00361a396177a9c, 414140de5dae2223, ba7816bf8f01cfea; data_out_last never asserted.
- Control during the 4th word:
  - Stimulus: en=0 for 5 cycles, then en=1.
  - Required: no fires while en=0, then resume at word 4.
  - Stimulus: sync_rst for 1 cycle at word 4.
  - Required: valid=0, cnt=0, status_hash_cnt=0; the next digest starts at word 0.
- Asynchronous reset:
  - Stimulus: nrst pulsed low between clk edges mid-digest.
  - Required: outputs reset immediately without a clock edge.
